rocc_cmd_resp_queue: RTL

//  Decoupling stage between the core's RoCC port and a RoCC accelerator.
//  - Buffers commands in one FIFO and responses in another.
//  - Uses response credits so the accelerator's resp_ready can be held high.
//  - Drives the aggregate busy flag back to the core.

---
 rtl/rocc_cmd_resp_queue_pkg.sv | 21 ++
 rtl/rocc_cmd_resp_queue_fifo.sv | 61 ++++++
 rtl/rocc_cmd_resp_queue.sv | 133 +++++++++++++
 3 files changed

// File: rtl/rocc_cmd_resp_queue_pkg.sv
// Shared RoCC field positions and command/response record types.
package rocc_pkg;

  localparam int unsigned ROCC_XLEN    = 64;
  localparam int unsigned ROCC_XD_BIT  = 14;
  localparam int unsigned ROCC_XS1_BIT = 13;
  localparam int unsigned ROCC_XS2_BIT = 12;
  localparam int unsigned ROCC_RD_LSB  = 7;

  typedef struct packed {
    logic [31:0]          inst;
    logic [ROCC_XLEN-1:0] rs1;
    logic [ROCC_XLEN-1:0] rs2;
  } rocc_cmd_t;

  typedef struct packed {
    logic [4:0]           rd;
    logic [ROCC_XLEN-1:0] data;
  } rocc_resp_t;

endpackage

// File: rtl/rocc_cmd_resp_queue_fifo.sv
// Synchronous FIFO with registered output (no fall-through); wrap-bit pointers.
module rocc_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  // Full when addresses match but the wrap bits differ; push is blocked even if a pop coincides.
  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/rocc_cmd_resp_queue.sv
// RoCC decoupling stage: command and response FIFOs, response-credit accounting, busy and overflow flags.
module rocc_cmd_resp_queue
  import rocc_pkg::*;
#(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned CMD_DEPTH  = 4,
  parameter int unsigned RESP_DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            core_cmd_valid,
  output logic            core_cmd_ready,
  input  logic [31:0]     core_cmd_inst,
  input  logic [XLEN-1:0] core_cmd_rs1,
  input  logic [XLEN-1:0] core_cmd_rs2,
  output logic            acc_cmd_valid,
  input  logic            acc_cmd_ready,
  output logic [31:0]     acc_cmd_inst,
  output logic [XLEN-1:0] acc_cmd_rs1,
  output logic [XLEN-1:0] acc_cmd_rs2,
  input  logic            acc_resp_valid,
  output logic            acc_resp_ready,
  input  logic [4:0]      acc_resp_rd,
  input  logic [XLEN-1:0] acc_resp_data,
  output logic            core_resp_valid,
  input  logic            core_resp_ready,
  output logic [4:0]      core_resp_rd,
  output logic [XLEN-1:0] core_resp_data,
  input  logic            acc_busy,
  output logic            core_busy,
  output logic            err_resp_ovf
);

  localparam int unsigned CAW    = $clog2(CMD_DEPTH);
  localparam int unsigned RAW    = $clog2(RESP_DEPTH);
  localparam int unsigned CMD_W  = 32 + 2 * XLEN;
  localparam int unsigned RESP_W = 5 + XLEN;
  localparam logic [RAW:0] OUT_ONE   = 1;
  localparam logic [RAW:0] RESP_FULL = (RAW+1)'(RESP_DEPTH);

  logic             active_q, active_d;
  logic [RAW:0]     outstanding_q, outstanding_d;
  logic             err_q, err_d;

  logic [CMD_W-1:0] cmd_dout;
  logic             cmd_full, cmd_empty, cmd_push, cmd_pop;
  logic [CAW:0]     cmd_count;
  logic [RESP_W-1:0] resp_dout;
  logic             resp_full, resp_empty, resp_push, resp_pop;
  logic [RAW:0]     resp_count;
  logic             unused_resp_full;

  logic             cmd_xd, xd_push, resp_arrive, resp_drop, credit_avail;
  logic [RAW:0]     used_slots;

  assign cmd_xd       = core_cmd_inst[ROCC_XD_BIT];
  // A credit is a response slot not yet claimed by an in-flight xd command or a buffered response.
  assign used_slots   = outstanding_q + resp_count;
  assign credit_avail = (used_slots != RESP_FULL);

  assign core_cmd_ready = active_q && !cmd_full && (!cmd_xd || credit_avail);
  assign cmd_push       = core_cmd_valid && core_cmd_ready;
  assign xd_push        = cmd_push && cmd_xd;
  assign acc_cmd_valid  = !cmd_empty;
  assign cmd_pop        = acc_cmd_valid && acc_cmd_ready;
  assign {acc_cmd_inst, acc_cmd_rs1, acc_cmd_rs2} = cmd_dout;

  assign acc_resp_ready  = active_q;
  assign resp_arrive     = acc_resp_valid && active_q;
  assign resp_push       = resp_arrive && (outstanding_q != '0);
  assign resp_drop       = resp_arrive && (outstanding_q == '0);
  assign core_resp_valid = !resp_empty;
  assign resp_pop        = core_resp_valid && core_resp_ready;
  assign {core_resp_rd, core_resp_data} = resp_dout;
  assign unused_resp_full = resp_full;

  assign core_busy    = (cmd_count != '0) || (outstanding_q != '0) || (resp_count != '0) || acc_busy;
  assign err_resp_ovf = err_q;

  always_comb begin
    active_d      = 1'b1;
    err_d         = err_q | resp_drop;
    outstanding_d = outstanding_q;
    case ({xd_push, resp_push})
      2'b10:   outstanding_d = outstanding_q + OUT_ONE;
      2'b01:   outstanding_d = outstanding_q - OUT_ONE;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      active_q      <= 1'b0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      active_q      <= active_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  rocc_sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk   (clock),
    .rst_n (reset),
    .push  (cmd_push),
    .din   ({core_cmd_inst, core_cmd_rs1, core_cmd_rs2}),
    .pop   (cmd_pop),
    .dout  (cmd_dout),
    .full  (cmd_full),
    .empty (cmd_empty),
    .count (cmd_count)
  );

  rocc_sync_fifo #(
    .WIDTH (RESP_W),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk   (clock),
    .rst_n (reset),
    .push  (resp_push),
    .din   ({acc_resp_rd, acc_resp_data}),
    .pop   (resp_pop),
    .dout  (resp_dout),
    .full  (resp_full),
    .empty (resp_empty),
    .count (resp_count)
  );

endmodule
